// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter for a 4x16 register file: one-entry buffer per port, round-robin grant, 2-cycle latency.
// Define WRARB_FIXED_PRIO_EN to make requester A always win ties.
module regfile_wr_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [2:0]  a_addr,
   input  logic [15:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [2:0]  b_addr,
   input  logic [15:0] b_data,
   output logic        rf_write,
   output logic [2:0]  rf_wrAddr,
   output logic [15:0] rf_wrData,
   output logic        err_addr,
   output logic [7:0]  wr_cnt
);

   logic        a_vld_q, a_vld_d, a_rdy_q;
   logic [2:0]  a_addr_q;
   logic [15:0] a_data_q;
   logic        b_vld_q, b_vld_d, b_rdy_q;
   logic [2:0]  b_addr_q;
   logic [15:0] b_data_q;

   logic        rf_write_q, err_q;
   logic [2:0]  rf_addr_q;
   logic [15:0] rf_data_q;
   logic [7:0]  cnt_q, cnt_d;

   logic        a_take, b_take, any_vld, grant_b;
   logic [2:0]  win_addr;
   logic [15:0] win_data;
   logic        issue_wr, issue_err;

`ifndef WRARB_FIXED_PRIO_EN
   // 1 = B was granted last; reset value lets A win the first tie.
   logic        last_grant_q, last_grant_d;
`endif

   always_comb begin
      a_take  = a_valid && a_rdy_q;
      b_take  = b_valid && b_rdy_q;
      any_vld = a_vld_q || b_vld_q;
`ifdef WRARB_FIXED_PRIO_EN
      grant_b = b_vld_q && !a_vld_q;
`else
      grant_b = b_vld_q && (!a_vld_q || !last_grant_q);
      last_grant_d = any_vld ? grant_b : last_grant_q;
`endif
      win_addr  = grant_b ? b_addr_q : a_addr_q;
      win_data  = grant_b ? b_data_q : a_data_q;
      issue_wr  = any_vld && !win_addr[2];
      issue_err = any_vld && win_addr[2];

      // A buffer is only refillable while empty, so clear and fill never coincide.
      a_vld_d = a_vld_q;
      if (any_vld && !grant_b) a_vld_d = 1'b0;
      if (a_take)              a_vld_d = 1'b1;
      b_vld_d = b_vld_q;
      if (any_vld && grant_b)  b_vld_d = 1'b0;
      if (b_take)              b_vld_d = 1'b1;

      cnt_d = cnt_q;
      if (issue_wr && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_vld_q    <= 1'b0;
         a_rdy_q    <= 1'b1;
         a_addr_q   <= 3'd0;
         a_data_q   <= 16'd0;
         b_vld_q    <= 1'b0;
         b_rdy_q    <= 1'b1;
         b_addr_q   <= 3'd0;
         b_data_q   <= 16'd0;
         rf_write_q <= 1'b0;
         err_q      <= 1'b0;
         rf_addr_q  <= 3'd0;
         rf_data_q  <= 16'd0;
         cnt_q      <= 8'd0;
`ifndef WRARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         a_vld_q <= a_vld_d;
         a_rdy_q <= !a_vld_d;
         b_vld_q <= b_vld_d;
         b_rdy_q <= !b_vld_d;
         if (a_take) begin
            a_addr_q <= a_addr;
            a_data_q <= a_data;
         end
         if (b_take) begin
            b_addr_q <= b_addr;
            b_data_q <= b_data;
         end
         rf_write_q <= issue_wr;
         err_q      <= issue_err;
         if (issue_wr) begin
            rf_addr_q <= win_addr;
            rf_data_q <= win_data;
         end
         cnt_q <= cnt_d;
`ifndef WRARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign a_ready   = a_rdy_q;
   assign b_ready   = b_rdy_q;
   assign rf_write  = rf_write_q;
   assign rf_wrAddr = rf_addr_q;
   assign rf_wrData = rf_data_q;
   assign err_addr  = err_q;
   assign wr_cnt    = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed vectors push expected issues, a negedge monitor pops and compares.
module tb_regfile_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [2:0]  a_addr, b_addr;
   logic [15:0] a_data, b_data;
   logic        rf_write, err_addr;
   logic [2:0]  rf_wrAddr;
   logic [15:0] rf_wrData;
   logic [7:0]  wr_cnt;

   typedef struct packed {
      logic        is_err;
      logic [2:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   regfile_wr_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
      .err_addr(err_addr), .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && (rf_write === 1'b1 || err_addr === 1'b1)) begin
         n_total++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_issue: got wr=%0b err=%0b addr=%0h data=%0h expected nothing",
                     rf_write, err_addr, rf_wrAddr, rf_wrData);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (rf_write !== !e.is_err || err_addr !== e.is_err ||
                (!e.is_err && (rf_wrAddr !== e.addr || rf_wrData !== e.data))) begin
               n_bad++;
               $display("FAIL issue: got wr=%0b err=%0b addr=%0h data=%0h expected err=%0b addr=%0h data=%0h",
                        rf_write, err_addr, rf_wrAddr, rf_wrData, e.is_err, e.addr, e.data);
            end
         end
      end
   end

   task automatic wait_ready(input bit want_a, input bit want_b);
      int n = 0;
      while (!((!want_a || a_ready) && (!want_b || b_ready)) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         n_total++;
         n_bad++;
         $display("FAIL ready_timeout: got a_ready=%0b b_ready=%0b expected ready within 50 cycles", a_ready, b_ready);
      end
   endtask

   task automatic send_a(input logic [2:0] ad, input logic [15:0] d);
      wait_ready(1'b1, 1'b0);
      a_addr = ad; a_data = d; a_valid = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [2:0] aa, input logic [15:0] ad,
                            input logic [2:0] ba, input logic [15:0] bd);
      wait_ready(1'b1, 1'b1);
      a_addr = aa; a_data = ad; a_valid = 1'b1;
      b_addr = ba; b_data = bd; b_valid = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic push(input logic is_err, input logic [2:0] ad, input logic [15:0] d);
      exp_t e;
      e.is_err = is_err; e.addr = ad; e.data = d;
      q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         n_total++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_a_ready"},   a_ready,   1);
      chk({tag, "_b_ready"},   b_ready,   1);
      chk({tag, "_rf_write"},  rf_write,  0);
      chk({tag, "_rf_wrAddr"}, rf_wrAddr, 0);
      chk({tag, "_rf_wrData"}, rf_wrData, 0);
      chk({tag, "_err_addr"},  err_addr,  0);
      chk({tag, "_wr_cnt"},    wr_cnt,    0);
   endtask

   initial begin
      logic [15:0] pend_data;
      logic [15:0] fin_data;
      logic [2:0]  fin_addr;
      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0;
      a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
      #1;
      do_reset();
      chk_reset_vals("reset");

      // Single write: latency 2, one-cycle strobe, ready handshake.
      push(1'b0, 3'd2, 16'h1234);
      send_a(3'd2, 16'h1234);
      chk("lat_a_ready_low", a_ready, 0);
      chk("lat_wr_early", rf_write, 0);
      @(posedge clk); #1;
      chk("lat_wr_high", rf_write, 1);
      chk("lat_addr", rf_wrAddr, 2);
      chk("lat_data", rf_wrData, 16'h1234);
      chk("lat_a_ready_back", a_ready, 1);
      @(posedge clk); #1;
      chk("lat_wr_pulse_end", rf_write, 0);
      chk("lat_data_hold", rf_wrData, 16'h1234);
      drain();
      chk("cnt_after_1", wr_cnt, 1);

      // Tie right after reset: A first, B data persists.
      do_reset();
      push(1'b0, 3'd1, 16'hAAAA);
      push(1'b0, 3'd1, 16'h5555);
      send_pair(3'd1, 16'hAAAA, 3'd1, 16'h5555);
      drain();
      chk("tie1_final_data", rf_wrData, 16'h5555);

      // A alone, then a second tie: round-robin favours B, fixed priority favours A.
      push(1'b0, 3'd3, 16'h0303);
      send_a(3'd3, 16'h0303);
      drain();
`ifdef WRARB_FIXED_PRIO_EN
      push(1'b0, 3'd0, 16'h1111);
      push(1'b0, 3'd0, 16'h2222);
      fin_data = 16'h2222;
`else
      push(1'b0, 3'd0, 16'h2222);
      push(1'b0, 3'd0, 16'h1111);
      fin_data = 16'h1111;
`endif
      send_pair(3'd0, 16'h1111, 3'd0, 16'h2222);
      drain();
      chk("tie2_final_data", rf_wrData, fin_data);
      chk("cnt_after_5", wr_cnt, 5);

      // Out-of-range write: error pulse, no write, nothing else moves.
      push(1'b1, 3'd5, 16'hFFFF);
      send_a(3'd5, 16'hFFFF);
      drain();
      chk("err_cnt_unchanged", wr_cnt, 5);
      chk("err_addr_hold", rf_wrAddr, 0);
      chk("err_data_hold", rf_wrData, fin_data);
      chk("err_a_ready", a_ready, 1);

      // The dropped write counted as an A grant, so the next tie goes to B first.
`ifdef WRARB_FIXED_PRIO_EN
      push(1'b0, 3'd2, 16'h2A2A);
      push(1'b0, 3'd3, 16'h3B3B);
      fin_addr = 3'd3; fin_data = 16'h3B3B;
`else
      push(1'b0, 3'd3, 16'h3B3B);
      push(1'b0, 3'd2, 16'h2A2A);
      fin_addr = 3'd2; fin_data = 16'h2A2A;
`endif
      send_pair(3'd2, 16'h2A2A, 3'd3, 16'h3B3B);
      drain();
      chk("tie3_final_addr", rf_wrAddr, fin_addr);
      chk("tie3_final_data", rf_wrData, fin_data);
      chk("cnt_after_7", wr_cnt, 7);

      // Reset one cycle after a transfer discards the pending write.
      pend_data = 16'hBEEF;
      send_a(3'd2, pend_data);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk_reset_vals("midrst");

      // Transfers offered while in reset are ignored.
      rst = 1'b1;
      a_addr = 3'd1; a_data = 16'h7777; a_valid = 1'b1;
      b_addr = 3'd2; b_data = 16'h8888; b_valid = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk_reset_vals("rstxfer");

      // 260 writes: counter saturates at 255.
      for (int i = 0; i < 130; i++) begin
         logic [2:0]  aa, ba;
         logic [15:0] ad, bd;
         aa = 3'(i % 4); ba = 3'((i + 1) % 4);
         ad = 16'(i);    bd = ~16'(i);
         push(1'b0, aa, ad);
         push(1'b0, ba, bd);
         send_pair(aa, ad, ba, bd);
      end
      drain();
      chk("cnt_saturated", wr_cnt, 255);
      chk("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The module SHALL have one clock, clk, and a synchronous, active-high reset, rst; there SHALL be no other clock or reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 a_valid  input  1  requester A write request.
REQ-005 a_ready  output  1  requester A buffer empty; a transfer occurs when a_valid and a_ready are both high at a rising edge.
REQ-006 a_addr  input  3  requester A target register.
REQ-007 a_data  input  16  requester A write data.
REQ-008 b_valid, b_ready, b_addr, b_data SHALL match the A ports (same directions, widths 1/1/3/16) for requester B.
REQ-009 rf_write  output  1  write strobe to the 4x16 register file.
REQ-010 rf_wrAddr  output  3  register-file write address.
REQ-011 rf_wrData  output  16  register-file write data.
REQ-012 err_addr  output  1  one-cycle pulse when an out-of-range write is dropped.
REQ-013 wr_cnt  output  8  saturating count of writes issued to the register file.

Function
REQ-014 Each port SHALL have a one-entry buffer (valid flag, address, data); x_ready SHALL be registered and equal to NOT buffer-valid.
REQ-015 On a transfer at edge E, the buffer SHALL become valid after E and x_ready SHALL be 0 in the following cycle.
REQ-016 In every cycle where at least one buffer is valid, the arbiter SHALL select exactly one winner combinationally; at the next edge it SHALL issue the winner and clear that buffer.
REQ-017 Arbitration SHALL be round-robin: if both buffers are valid, grant the port not granted last; if one is valid, grant it; last_grant SHALL update on every grant.
REQ-018 Issue of an address 0..3 SHALL register rf_write=1, rf_wrAddr=addr and rf_wrData=data for exactly one cycle.
REQ-019 Issue of an address 4..7 SHALL keep rf_write=0, pulse err_addr=1 for one cycle, leave rf_wrAddr/rf_wrData unchanged, and still count as a grant for round-robin.
REQ-020 rf_wrAddr and rf_wrData SHALL hold their last values when no write is issued.
REQ-021 Latency SHALL be 2 cycles: transfer at edge E, then rf_write high in the cycle after edge E+1.
REQ-022 Aggregate throughput SHALL be one issue per cycle; each port SHALL accept at most one transfer every 2 cycles.
REQ-023 A buffer cleared at edge E SHALL assert x_ready in the cycle after E; no same-cycle refill is allowed.
REQ-024 Simultaneous writes to the same address from A and B SHALL issue on consecutive cycles in round-robin order, so the later-granted data persists.
REQ-025 wr_cnt SHALL increment by 1 on each rf_write=1 cycle and saturate at 255.

Reset
REQ-026 While rst is high at an edge, both buffers SHALL clear and pending writes SHALL be discarded, including writes arriving mid-operation.
REQ-027 Reset SHALL set a_ready=b_ready=1 in the following cycle, rf_write=0, rf_wrAddr=0, rf_wrData=0, err_addr=0, wr_cnt=0, and last_grant=B so that A wins the first tie.
REQ-028 Transfers presented during a reset cycle SHALL be ignored.

Configuration
REQ-029 Macro WRARB_FIXED_PRIO_EN: when defined, requester A SHALL always win ties and last_grant SHALL be unused.
REQ-030 When WRARB_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-017; all other behaviour SHALL be identical in both builds.

Verification
REQ-031 After reset, A sends addr=2, data=16'h1234 -> 2 cycles later rf_write=1, rf_wrAddr=2, rf_wrData=16'h1234 for one cycle; wr_cnt=1.
REQ-032 A (addr=1, 16'hAAAA) and B (addr=1, 16'h5555) transfer on the same edge -> A issues, then B issues on the next cycle; 16'h5555 is the final write. With WRARB_FIXED_PRIO_EN defined, A also wins a repeat tie.
REQ-033 Round-robin check: after REQ-032, a second simultaneous pair -> B issues before A.
REQ-034 A sends addr=5, data=16'hFFFF -> err_addr pulses once, rf_write stays 0, wr_cnt is unchanged, and a_ready returns to 1.
REQ-035 rst asserted one cycle after an A transfer -> no rf_write occurs, all outputs match reset values, and a_ready=1.
REQ-036 Issue 260 valid writes -> wr_cnt saturates at 255.
